prenc_reg: RTL and testbench
============================

Name: prenc_reg

Overview:
- Registered 8-input priority encoder.
- Reports the index of the highest-priority asserted request bit on a 3-bit output, plus a valid flag that distinguishes "bit 0 set" from "no bit set".
- Used as a request/interrupt index generator between a request vector source and downstream arbitration or dispatch logic.
- Single clock domain, one-cycle registered latency.

Parameters:
- WIDTH, 8, number of request input bits; must be a power of two, minimum 2.
- IDX_W, $clog2(WIDTH) (3 at default), width of the index output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when high, the output registers update on the clock edge.
- lsb_pri  input  1  priority direction: 0 means the highest index wins; 1 means the lowest index wins.
- a  input  WIDTH  request vector.
- y  output  IDX_W  encoded index of the winning request bit.
- valid  output  1  high when at least one bit of the captured a was set.
- onehot  output  WIDTH  one-hot mask of the winning bit; all zeros when valid is 0.

Behaviour:
- Reset: when rst_n goes low, y=0, valid=0 and onehot=0 immediately, with no clock needed. These values hold while rst_n is low. Release takes effect at the first rising clk edge after rst_n goes high.
- Encoding is purely combinational from a and lsb_pri. All three outputs are registered.
- Latency is 1 cycle: values sampled at edge N appear after edge N.
- en=0: all output registers hold their previous values, regardless of a or lsb_pri.
- lsb_pri=0 (default use): y = index of the most-significant set bit of a.
  - a=8'b0000_0011 gives y=1.
  - a=8'b0000_0101 gives y=2.
  - a=8'b1000_0001 gives y=7.
- lsb_pri=1: y = index of the least-significant set bit of a.
  - a=8'b0000_0110 gives y=1.
  - a=8'b1000_0000 gives y=7.
- a=0: y=0, valid=0, onehot=0, in both priority modes.
- Any nonzero a: valid=1, and onehot has exactly one bit set, at position y.
- X/Z on a is not defined behaviour; the bench drives known values only.
- Implementation is a generic loop or priority chain scaled by WIDTH. A hard-coded case table is not permitted.
- Reset asserted mid-operation: outputs clear asynchronously. No stale value appears after reset release until the next enabled capture.
- lsb_pri and a changing in the same cycle: both are sampled on the same edge, with no ordering hazard.

Test Plan:
- Reset and empty: hold rst_n=0 and drive a=8'hFF → y=0, valid=0, onehot=0 throughout. Release reset, then a=0, en=1 → after one edge, y=0, valid=0.
- Single bits: with en=1 and lsb_pri=0, sweep a=8'b1 << k for k=0..7 → after one edge, y=k, valid=1, onehot=a.
- Multi-bit, MSB priority: apply the sequence 00,01,02,03,04,05 (hex), one per cycle → next cycle y is 0,0,1,1,2,2 respectively, and valid is 0,1,1,1,1,1.
- LSB priority: lsb_pri=1 with a=8'hA8 → y=3, onehot=8'h08. Same a with lsb_pri=0 → y=7, onehot=8'h80.
- Enable hold: capture a=8'h10 (y=4), set en=0, change a to 8'h02 for 3 cycles → y stays 4 and valid stays 1. Set en=1 → y=1 after one edge.
- Async reset mid-stream: with y=6 and valid=1, pulse rst_n low between clock edges → outputs read 0 before the next edge. After release with a=8'h40 and en=1 → y=6 one edge later.

Source files
------------

// File: rtl/prenc_reg.sv
// Registered priority encoder: index, valid flag and one-hot mask of the winning request bit.
// Latency: one cycle from the capturing clk edge to y/valid/onehot.
// No backpressure: en=0 freezes the output registers, and a is ignored while frozen.
module prenc_reg #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             lsb_pri,
    input  logic [WIDTH-1:0] a,
    output logic [IDX_W-1:0] y,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic [WIDTH-1:0] win_mask;

    // Scan upward for MSB priority and downward for LSB priority.
    // The last set bit visited in either scan is the winner.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        if (lsb_pri) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (a[i]) begin
                    win_idx = IDX_W'(i);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (a[i]) begin
                    win_idx = IDX_W'(i);
                    win_vld = 1'b1;
                end
            end
        end
        win_mask = win_vld ? (WIDTH'(1) << win_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y      <= '0;
            valid  <= 1'b0;
            onehot <= '0;
        end else if (en) begin
            y      <= win_idx;
            valid  <= win_vld;
            onehot <= win_mask;
        end
    end

endmodule

// File: tb/tb_prenc_reg.sv
// Bench for prenc_reg: directed vector table, hand-written reset/enable sequences, and random traffic
// checked against an arithmetic reference model.
module tb_prenc_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       lsb_pri;
    logic [7:0] a;
    logic [2:0] y;
    logic       valid;
    logic [7:0] onehot;

    int nvec;
    int nerr;

    prenc_reg #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .lsb_pri(lsb_pri),
        .a      (a),
        .y      (y),
        .valid  (valid),
        .onehot (onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lsb;
        logic [7:0] a;
        logic [2:0] y;
        logic       v;
        logic [7:0] oh;
    } vec_t;

    vec_t tbl[$];

    // Reference: MSB index is floor(log2(a)); LSB index is log2 of the isolated lowest set bit.
    function automatic void model(input logic lsb, input logic [7:0] av,
                                  output logic [2:0] ey, output logic ev, output logic [7:0] eoh);
        int unsigned n;
        int unsigned low;
        n = av;
        if (n == 0) begin
            ey = '0; ev = 1'b0; eoh = '0;
        end else begin
            if (lsb) begin
                low = n & (~n + 1);
                ey  = 3'($clog2(low));
            end else begin
                ey  = 3'($clog2(n + 1) - 1);
            end
            ev  = 1'b1;
            eoh = 8'(1 << ey);
        end
    endfunction

    task automatic check(input string name, input logic [2:0] ey, input logic ev, input logic [7:0] eoh);
        nvec++;
        if (y !== ey || valid !== ev || onehot !== eoh) begin
            nerr++;
            $display("FAIL %s: got y=%0d valid=%0b onehot=%02h, want y=%0d valid=%0b onehot=%02h",
                     name, y, valid, onehot, ey, ev, eoh);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic l, input logic [7:0] av, input logic [2:0] ey,
                                input logic ev, input logic [7:0] eoh);
        vec_t t;
        t.lsb = l; t.a = av; t.y = ey; t.v = ev; t.oh = eoh;
        return t;
    endfunction

    initial begin
        logic [2:0] my;
        logic       mv;
        logic [7:0] moh;
        logic [7:0] bit_k;

        nvec = 0;
        nerr = 0;

        // Reset held with all requests set: outputs stay cleared.
        rst_n = 1'b0; en = 1'b1; lsb_pri = 1'b0; a = 8'hFF;
        #2;
        check("reset_immediate", 3'd0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", 3'd0, 1'b0, 8'h00);
        end
        rst_n = 1'b1; a = 8'h00;
        step();
        check("empty_after_release", 3'd0, 1'b0, 8'h00);

        for (int k = 0; k < 8; k++) begin
            bit_k = 8'h01 << k;
            tbl.push_back(mk(1'b0, bit_k, 3'(k), 1'b1, bit_k));
        end
        tbl.push_back(mk(1'b0, 8'h00, 3'd0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 8'h01, 3'd0, 1'b1, 8'h01));
        tbl.push_back(mk(1'b0, 8'h02, 3'd1, 1'b1, 8'h02));
        tbl.push_back(mk(1'b0, 8'h03, 3'd1, 1'b1, 8'h02));
        tbl.push_back(mk(1'b0, 8'h04, 3'd2, 1'b1, 8'h04));
        tbl.push_back(mk(1'b0, 8'h05, 3'd2, 1'b1, 8'h04));
        tbl.push_back(mk(1'b0, 8'h81, 3'd7, 1'b1, 8'h80));
        tbl.push_back(mk(1'b1, 8'h06, 3'd1, 1'b1, 8'h02));
        tbl.push_back(mk(1'b1, 8'h80, 3'd7, 1'b1, 8'h80));
        tbl.push_back(mk(1'b1, 8'hA8, 3'd3, 1'b1, 8'h08));
        tbl.push_back(mk(1'b0, 8'hA8, 3'd7, 1'b1, 8'h80));
        tbl.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 8'hFF, 3'd0, 1'b1, 8'h01));
        tbl.push_back(mk(1'b0, 8'hFF, 3'd7, 1'b1, 8'h80));

        en = 1'b1;
        foreach (tbl[i]) begin
            lsb_pri = tbl[i].lsb;
            a       = tbl[i].a;
            step();
            check($sformatf("table[%0d] a=%02h lsb=%0b", i, tbl[i].a, tbl[i].lsb),
                  tbl[i].y, tbl[i].v, tbl[i].oh);
        end

        // Enable hold.
        lsb_pri = 1'b0; a = 8'h10; en = 1'b1;
        step();
        check("hold_capture", 3'd4, 1'b1, 8'h10);
        en = 1'b0; a = 8'h02;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_frozen", 3'd4, 1'b1, 8'h10);
        end
        en = 1'b1;
        step();
        check("hold_release", 3'd1, 1'b1, 8'h02);

        // Async reset between edges, then no stale value until an enabled capture.
        a = 8'h40;
        step();
        check("pre_reset", 3'd6, 1'b1, 8'h40);
        #2 rst_n = 1'b0;
        #1 check("async_clear", 3'd0, 1'b0, 8'h00);
        step();
        check("reset_edge_hold", 3'd0, 1'b0, 8'h00);
        rst_n = 1'b1; en = 1'b0;
        step();
        check("no_stale_after_release", 3'd0, 1'b0, 8'h00);
        en = 1'b1;
        step();
        check("post_reset_capture", 3'd6, 1'b1, 8'h40);

        // Random traffic against the reference model.
        model(lsb_pri, a, my, mv, moh);
        for (int i = 0; i < 400; i++) begin
            a       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            lsb_pri = 1'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            if (en) model(lsb_pri, a, my, mv, moh);
            step();
            check($sformatf("rand[%0d] a=%02h lsb=%0b en=%0b", i, a, lsb_pri, en), my, mv, moh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
